// File: rtl/mem_init_pkg.sv
// Shared types for the memory-initialisation fill engine.
package mem_init_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 8;

  // Fill pattern; the reserved code behaves as identity.
  typedef enum logic [1:0] {
    MODE_IDENT = 2'd0,
    MODE_CONST = 2'd1,
    MODE_DESC  = 2'd2,
    MODE_RSVD  = 2'd3
  } fill_mode_e;

  // Engine control state.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/mem_init_datagen.sv
// Registered address/data pattern generator for the fill engine.
module mem_init_datagen
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  fill_mode_e        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata
);

  // Remaining-count register feeding the descending pattern (len-1-i).
  logic [ADDR_W-1:0] desc_q;
  logic [ADDR_W-1:0] addr_nx;
  logic [ADDR_W-1:0] desc_nx;
  logic [DATA_W-1:0] data_nx;

  // Next address/count/data: load starts the range, advance steps it.
  always_comb begin
    addr_nx = addr;
    desc_nx = desc_q;
    data_nx = wrdata;
    if (load) begin
      addr_nx = base;
      desc_nx = ADDR_W'(len - (ADDR_W + 1)'(1));
    end else if (advance) begin
      addr_nx = addr + ADDR_W'(1);
      desc_nx = desc_q - ADDR_W'(1);
    end
    if (load || advance) begin
      case (mode)
        MODE_CONST: data_nx = fill;
        MODE_DESC:  data_nx = DATA_W'(desc_nx);
        default:    data_nx = DATA_W'(addr_nx);
      endcase
    end
  end

  // Pattern registers; held unchanged on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr   <= '0;
      desc_q <= '0;
      wrdata <= '0;
    end else begin
      addr   <= addr_nx;
      desc_q <= desc_nx;
      wrdata <= data_nx;
    end
  end

endmodule

// File: rtl/mem_init_fill.sv
// Programmable-range RAM fill engine with grant-based write handshake.
module mem_init_fill
  import mem_init_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              rdy,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] fill,
  input  logic              abort,
  input  logic              gnt,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  output logic              done
);

  state_e            state_q, state_d;
  fill_mode_e        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] fill_q;
  logic [ADDR_W-1:0] idx_q, idx_d;

  logic rdy_d, wren_d, done_d;
  logic load_c, advance_c, last_c;

  fill_mode_e        gen_mode_c;
  logic [ADDR_W-1:0] gen_base_c;
  logic [ADDR_W:0]   gen_len_c;
  logic [DATA_W-1:0] gen_fill_c;

  // Final word of the range is the one at index len-1.
  assign last_c = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

  // Generator sees the incoming request on the accept cycle, latched copy after.
  assign gen_mode_c = load_c ? fill_mode_e'(mode) : mode_q;
  assign gen_base_c = load_c ? base : base_q;
  assign gen_len_c  = load_c ? len  : len_q;
  assign gen_fill_c = load_c ? fill : fill_q;

  // Next-state and registered-output decode.
  always_comb begin
    state_d   = state_q;
    rdy_d     = rdy;
    wren_d    = wren;
    done_d    = 1'b0;
    load_c    = 1'b0;
    advance_c = 1'b0;
    idx_d     = idx_q;
    unique case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        wren_d = 1'b0;
        if (en) begin
          load_c = 1'b1;
          idx_d  = '0;
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FILL;
            rdy_d   = 1'b0;
            wren_d  = 1'b1;
          end
        end
      end
      FILL: begin
        rdy_d  = 1'b0;
        wren_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          wren_d  = 1'b0;
        end else if (gnt) begin
          if (last_c) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            wren_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            advance_c = 1'b1;
            idx_d     = idx_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, latched request and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mode_q  <= MODE_IDENT;
      base_q  <= '0;
      len_q   <= '0;
      fill_q  <= '0;
      rdy     <= 1'b1;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rdy     <= rdy_d;
      wren    <= wren_d;
      done    <= done_d;
      if (load_c) begin
        mode_q <= fill_mode_e'(mode);
        base_q <= base;
        len_q  <= len;
        fill_q <= fill;
      end
    end
  end

  // Address/data pattern generation.
  mem_init_datagen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_datagen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_c),
    .advance (advance_c),
    .mode    (gen_mode_c),
    .base    (gen_base_c),
    .len     (gen_len_c),
    .fill    (gen_fill_c),
    .addr    (addr),
    .wrdata  (wrdata)
  );

endmodule
